// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 2-flop input synchronizer and valid/ready byte output.
// Define UART_RX_PARITY_EN to add a parity bit (sense set by PARITY_ODD) before the stop bit.
//   state    | meaning
//   S_IDLE   | line idle, waiting for a falling edge
//   S_START  | half a bit into the start bit, confirming it is still low
//   S_DATA   | sampling 8 data bits, LSB first
//   S_PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
//   S_STOP   | sampling the stop bit, delivering or flagging the frame
//   S_BREAK  | line held low after a framing error, waiting for idle
module uart_rx_core #(
    parameter logic [31:0] UART_BAUD  = 32'd271,
    parameter logic        PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic [31:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_sr;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_frame_err;
    logic        r_overrun;
    logic        w_rxs;
    logic        w_tick;
`ifdef UART_RX_PARITY_EN
    logic        r_par_bad;
    logic        r_parity_err;
`endif

    assign w_rxs  = r_sync2;
    assign w_tick = (r_state != S_IDLE) && (r_cnt == 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 32'd0;
            r_bit       <= 3'd0;
            r_sr        <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (r_valid && rx_ready)
                r_valid <= 1'b0;

            if (r_state == S_IDLE) begin
                if (!w_rxs) begin
                    r_cnt   <= UART_BAUD >> 1;
                    r_state <= S_START;
                end
            end else if (r_state == S_BREAK) begin
                // Leave immediately on idle so a following start bit is not missed.
                if (w_rxs)
                    r_state <= S_IDLE;
            end else if (!w_tick) begin
                r_cnt <= r_cnt - 32'd1;
            end else begin
                r_cnt <= UART_BAUD - 32'd1;
                case (r_state)
                    S_START: begin
                        if (!w_rxs) begin
                            r_bit   <= 3'd0;
                            r_state <= S_DATA;
`ifdef UART_RX_PARITY_EN
                            r_par_bad <= 1'b0;
`endif
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_DATA: begin
                        r_sr  <= {w_rxs, r_sr[7:1]};
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        r_par_bad <= w_rxs != ((^r_sr) ^ PARITY_ODD);
                        r_state   <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        if (!w_rxs) begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end else begin
                            r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (r_par_bad)
                                r_parity_err <= 1'b1;
                            else
`endif
                            if (r_valid && !rx_ready) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_data  <= r_sr;
                                r_valid <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign busy      = (r_state != S_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    // Parity sense is meaningless in the 8N1 build; referenced only to keep it a live parameter.
    assign parity_err = 1'b0 & PARITY_ODD;
`endif

endmodule
